// File: rtl/prio_encoder_hs.sv
// Purpose : latches rising edges on N request lines and presents the highest-index unmasked one.
// Latency : req rise before edge k -> pending after k -> valid/code after k+1; re-present earliest one edge after ack.
// Backpres: code/valid held stable until ack; new events keep accumulating in pending meanwhile.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high
//   req      N level request lines; an event is a 0->1 transition
//   mask     N bits, 1 = excluded from selection (the event is still latched)
//   ack      consumer accepts the presented code (ignored while valid = 0)
//   code     index of the presented request, highest index wins
//   valid    code is valid and held
//   any      OR of all pending bits, masked or not
//   pending  current pending register
//   overrun  sticky: an event arrived on a bit that was already pending
module prio_encoder_hs #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         any,
  output logic [N-1:0] pending,
  output logic         overrun
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] req_q;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [W-1:0] sel;
  logic [W-1:0] code_nxt;
  logic         found;

  assign rise  = req & ~req_q;
  assign cand  = pending & ~mask;
  assign any   = |pending;
  assign valid = (state == PRESENT);

  // Only the bit currently being presented is retired, and only on an
  // accepted handshake; ack while idle never touches pending.
  always_comb begin
    clr = '0;
    if (state == PRESENT && ack) begin
      clr[code] = 1'b1;
    end
  end

  // Ascending scan: later (higher) indices overwrite earlier ones, so the
  // highest unmasked pending bit wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        sel   = W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    case (state)
      IDLE: begin
        if (found) begin
          code_nxt  = sel;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        // No pre-emption: code is frozen until the consumer accepts it.
        if (ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      code  <= '0;
    end else begin
      state <= state_nxt;
      code  <= code_nxt;
    end
  end

  // req_q resets to 0 so a line already high at the first edge after reset
  // is seen as a fresh event. A rise coinciding with the clear of the same
  // bit is a new event: set wins and it does not count as an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      req_q   <= req;
      pending <= (pending & ~clr) | rise;
      overrun <= overrun | (|(rise & pending & ~clr));
    end
  end

endmodule

// File: tb/tb_prio_encoder_hs.sv
module tb_prio_encoder_hs;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic       any;
  logic [7:0] pending;
  logic       overrun;

  int n_checks;
  int n_fails;

  prio_encoder_hs #(.N(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .mask    (mask),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .any     (any),
    .pending (pending),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [7:0] pend;
    logic       valid;
    logic [2:0] code;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] p, input logic v,
                         input logic [2:0] c, input logic o);
    chk({tag, " pending"}, 32'(pending), 32'(p));
    chk({tag, " valid"},   32'(valid),   32'(v));
    chk({tag, " code"},    32'(code),    32'(c));
    chk({tag, " any"},     32'(any),     32'(|p));
    chk({tag, " overrun"}, 32'(overrun), 32'(o));
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] m, input logic a,
                     input logic [7:0] p, input logic v, input logic [2:0] c, input logic o);
    vec_t x;
    x.req = r; x.mask = m; x.ack = a; x.pend = p; x.valid = v; x.code = c; x.ov = o;
    vecs.push_back(x);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    req   = '0;
    mask  = '0;
    ack   = 1'b0;

    // Per-cycle table: inputs applied before an edge, outputs expected after it.
    //  req    mask   ack   pending valid code ov
    // single event on bit 5
    add(8'h20, 8'h00, 1'b0, 8'h20, 1'b0, 3'd0, 1'b0);
    add(8'h00, 8'h00, 1'b0, 8'h20, 1'b1, 3'd5, 1'b0);
    add(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 1'b0);
    // simultaneous events on 1, 3, 6 -> presented 6, 3, 1
    add(8'h4A, 8'h00, 1'b0, 8'h4A, 1'b0, 3'd5, 1'b0);
    add(8'h4A, 8'h00, 1'b0, 8'h4A, 1'b1, 3'd6, 1'b0);
    add(8'h4A, 8'h00, 1'b1, 8'h0A, 1'b0, 3'd6, 1'b0);
    add(8'h4A, 8'h00, 1'b0, 8'h0A, 1'b1, 3'd3, 1'b0);
    add(8'h4A, 8'h00, 1'b1, 8'h02, 1'b0, 3'd3, 1'b0);
    add(8'h4A, 8'h00, 1'b0, 8'h02, 1'b1, 3'd1, 1'b0);
    add(8'h4A, 8'h00, 1'b1, 8'h00, 1'b0, 3'd1, 1'b0);
    add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
    // req[2] held high 10 cycles -> exactly one event
    add(8'h04, 8'h00, 1'b0, 8'h04, 1'b0, 3'd1, 1'b0);
    add(8'h04, 8'h00, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0);
    add(8'h04, 8'h00, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0);
    add(8'h04, 8'h00, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0);
    add(8'h04, 8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0);
    for (int i = 0; i < 5; i++) add(8'h04, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0);
    // drop and re-raise req[2] while still pending -> sticky overrun
    add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0);
    add(8'h04, 8'h00, 1'b0, 8'h04, 1'b0, 3'd2, 1'b0);
    add(8'h00, 8'h00, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0);
    add(8'h04, 8'h00, 1'b0, 8'h04, 1'b1, 3'd2, 1'b1);
    add(8'h04, 8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 1'b1);
    add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 1'b1);
    // masking: pending 0x90, mask bit 7 -> 4; mask change mid-present ignored
    add(8'h90, 8'h80, 1'b0, 8'h90, 1'b0, 3'd2, 1'b1);
    add(8'h90, 8'h80, 1'b0, 8'h90, 1'b1, 3'd4, 1'b1);
    add(8'h10, 8'h10, 1'b0, 8'h90, 1'b1, 3'd4, 1'b1);
    add(8'h90, 8'h10, 1'b0, 8'h90, 1'b1, 3'd4, 1'b1);
    add(8'h90, 8'h10, 1'b1, 8'h80, 1'b0, 3'd4, 1'b1);
    add(8'h90, 8'h10, 1'b0, 8'h80, 1'b1, 3'd7, 1'b1);
    add(8'h90, 8'h10, 1'b1, 8'h00, 1'b0, 3'd7, 1'b1);
    add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd7, 1'b1);

    #2;
    chk_all("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    foreach (vecs[i]) begin
      req  = vecs[i].req;
      mask = vecs[i].mask;
      ack  = vecs[i].ack;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].pend, vecs[i].valid, vecs[i].code, vecs[i].ov);
    end

    // Rise on the presented bit exactly at the ack edge: set wins, no overrun.
    req = '0; mask = '0; ack = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    req = 8'h08;
    tick();
    tick();
    chk_all("ackrise present", 8'h08, 1'b1, 3'd3, 1'b0);
    req = 8'h00;
    tick();
    req = 8'h08;
    ack = 1'b1;
    tick();
    chk_all("ackrise at ack", 8'h08, 1'b0, 3'd3, 1'b0);
    ack = 1'b0;
    tick();
    chk_all("ackrise again", 8'h08, 1'b1, 3'd3, 1'b0);
    ack = 1'b1;
    tick();
    chk_all("ackrise done", 8'h00, 1'b0, 3'd3, 1'b0);

    // Async reset mid-PRESENT with everything pending and overrun set.
    ack = 1'b0;
    req = 8'h00;
    tick();
    req = 8'hFF;
    tick();
    tick();
    req = 8'h00;
    tick();
    req = 8'hFF;
    tick();
    chk_all("full present", 8'hFF, 1'b1, 3'd7, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async reset", 8'h00, 1'b0, 3'd0, 1'b0);
    req = 8'h00;
    tick();
    reset = 1'b0;
    ack = 1'b1;
    tick();
    tick();
    chk_all("ack idle", 8'h00, 1'b0, 3'd0, 1'b0);

    // A line already high when reset releases counts as an event.
    ack = 1'b0;
    reset = 1'b1;
    req = 8'h02;
    #2;
    reset = 1'b0;
    tick();
    chk_all("post-reset high", 8'h02, 1'b0, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/prio_encoder_hs.md
Name: prio_encoder_hs

Overview:
- Parametrised, registered priority encoder with request latching and a valid/ack handshake; successor to the team's 4-input combinational priority encoder.
- Captures rising edges on N request lines into a pending register and presents the highest-index unmasked pending request as a binary code.
- Holds each presented code until the consumer acknowledges it.
- Sits between raw event/interrupt sources and a single sequential consumer (controller or FSM).

Parameters:
N, 8, number of request inputs (N >= 2)
W, $clog2(N), code width (derived; not overridden by instantiator)

Ports:
clk      input   1   system clock, all state updates on rising edge
reset    input   1   asynchronous, active-high reset
req      input   N   request lines, level inputs, event = 0->1 transition
mask     input   N   1 = request bit excluded from selection (still latched)
ack      input   1   consumer accepts presented code
code     output  W   index of presented request, highest index wins
valid    output  1   code is valid and held stable
any      output  1   OR of all pending bits, masked or not
pending  output  N   current pending register
overrun  output  1   sticky: an event arrived on an already-pending bit

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (async assert, any time, including mid-handshake):
  - req_q = 0, pending = 0, code = 0, valid = 0, overrun = 0, state = IDLE.
  - Once reset releases, a req bit already high at the first edge counts as a rising edge.
- Edge detect:
  - req_q registers req every cycle.
  - rise[i] = req[i] & ~req_q[i], evaluated at each edge.
- Pending update, per bit, each edge:
  - rise[i] sets pending[i].
  - clr[i] clears pending[i], where clr[i] = (state == PRESENT) & ack & (code == i).
  - If rise[i] and clr[i] occur together, set wins and pending[i] stays 1.
  - That case is a new event, not an overrun.
- Overrun:
  - Set when rise[i] & pending[i] & ~clr[i] for any i.
  - Stays 1 until reset; no other clear.
- any = |pending, combinational from the pending register.
- Selection: sel = highest index i with pending[i] & ~mask[i]; found = at least one such bit.
- FSM, 2 states:
  - IDLE, valid = 0:
    - If found, at next edge code <= sel, valid <= 1, go to PRESENT.
    - Otherwise code holds its previous value.
  - PRESENT, valid = 1:
    - code and valid are held stable regardless of new requests or mask changes (no retraction, no pre-emption).
    - On an edge with ack = 1: clear pending[code], valid <= 0, go to IDLE.
    - code keeps its last value.
- ack while valid = 0 is ignored; it has no effect on pending.
- Latency:
  - req rises before edge k -> pending set after edge k -> valid = 1 after edge k+1.
  - After ack at edge m, valid = 0 for at least one cycle; the earliest next valid is after edge m+1.
- Masked pending bits:
  - Remain pending indefinitely and contribute to any.
  - Become selectable as soon as they are unmasked.
- Priority matches the 4-input encoder: index N-1 highest, index 0 lowest.

Test Plan:
1. Reset, then N=8, mask=0, pulse req[5] one cycle -> pending=0x20 after edge 1, valid=1 and code=5 after edge 2; ack one cycle -> valid=0, pending=0x00, any=0.
2. req[1], req[6] and req[3] rise in the same cycle -> presented order 6, 3, 1 across three ack handshakes, with one valid=0 cycle between each; overrun stays 0.
3. Hold req[2] high for 10 cycles -> exactly one pending event, code=2 once, overrun=0. Then drop req[2] and re-raise it before ack -> overrun=1 and stays 1 after ack.
4. pending=0x90 with mask=0x80 -> code=4; while presenting, set mask=0x10 and raise req[7] -> code stays 4 until ack, then code=7 presented next.
5. valid=1, code=3; at the ack edge req[3] rises -> pending[3] remains 1, overrun=0, code=3 presented again after the idle cycle.
6. Assert reset asynchronously mid-PRESENT, with pending=0xFF and overrun=1 -> all outputs 0 immediately, without waiting for a clock edge. With ack=1 and valid=0 after reset -> no change.
